// File: rtl/delay_timer_multi.sv
// delay_timer_multi: multi-channel programmable microsecond delay timer.
// Each channel counts whole microseconds with a prescaler (FREQ_MHZ clk
// cycles per microsecond) feeding a microsecond down-counter. Channels run
// one-shot or periodic and are completely independent of each other.
//
// Optional feature: define DELAY_TIMER_MULTI_PAUSE_EN to add the pause[]
// input, which freezes a running channel's counters while it is held high.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | channel inactive; no timing in progress, done = 0
// RUN     | counting toward the next expiry; busy = 1
// DONE    | one-shot (or zero delay) expiry reached; done = 1 until start/abort
module delay_timer_multi #(
  parameter int FREQ_MHZ    = 50,
  parameter int NUM_CH      = 4,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             start,
  input  logic [NUM_CH-1:0]             abort,
  input  logic [NUM_CH-1:0]             periodic,
  input  logic [NUM_CH*DELAY_WIDTH-1:0] delay_us,
`ifdef DELAY_TIMER_MULTI_PAUSE_EN
  input  logic [NUM_CH-1:0]             pause,
`endif
  output logic [NUM_CH-1:0]             busy,
  output logic [NUM_CH-1:0]             done,
  output logic [NUM_CH-1:0]             expire
);

  localparam int PW = (FREQ_MHZ > 1) ? $clog2(FREQ_MHZ) : 1;
  localparam logic [PW-1:0]          PRESC_MAX = PW'(FREQ_MHZ - 1);
  localparam logic [DELAY_WIDTH-1:0] REM_ONE   = DELAY_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                 state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [DELAY_WIDTH-1:0] rem_q, rem_d;
    logic [DELAY_WIDTH-1:0] reload_q, reload_d;
    logic                   mode_q, mode_d;
    logic                   busy_q, done_q, expire_q;
    logic                   busy_d, done_d, expire_d;
    logic                   expire_evt;
    logic                   run_en;
    logic [DELAY_WIDTH-1:0] delay_in;
    logic [PW-1:0]          base_presc;
    logic [DELAY_WIDTH-1:0] base_rem;
    logic [DELAY_WIDTH-1:0] base_reload;
    logic                   base_mode;
    logic                   tick_wrap;
    logic                   tick_hit;

    assign delay_in = delay_us[i*DELAY_WIDTH +: DELAY_WIDTH];

`ifdef DELAY_TIMER_MULTI_PAUSE_EN
    assign run_en = ~pause[i];
`else
    assign run_en = 1'b1;
`endif

    // The start cycle itself is the first prescaler tick (it is cycle 0 of
    // the delay), so a start ticks from the freshly loaded values rather
    // than from the old counters. This puts expiry in cycle N*FREQ_MHZ.
    assign base_presc  = start[i] ? '0          : presc_q;
    assign base_rem    = start[i] ? delay_in    : rem_q;
    assign base_reload = start[i] ? delay_in    : reload_q;
    assign base_mode   = start[i] ? periodic[i] : mode_q;
    assign tick_wrap   = (base_presc == PRESC_MAX);
    assign tick_hit    = tick_wrap && (base_rem == REM_ONE);

    // Next-state and counter update: abort beats start, start beats expiry.
    always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      rem_d      = rem_q;
      reload_d   = reload_q;
      mode_d     = mode_q;
      expire_evt = 1'b0;
      if (abort[i]) begin
        state_d = ST_IDLE;
        presc_d = '0;
        rem_d   = '0;
      end else if (start[i] && (delay_in == '0)) begin
        // Zero delay expires once and parks in DONE even in periodic mode,
        // otherwise it would re-trigger every cycle.
        state_d    = ST_DONE;
        presc_d    = '0;
        rem_d      = '0;
        reload_d   = '0;
        mode_d     = periodic[i];
        expire_evt = 1'b1;
      end else if (start[i] || (state_q == ST_RUN)) begin
        state_d  = ST_RUN;
        presc_d  = base_presc;
        rem_d    = base_rem;
        reload_d = base_reload;
        mode_d   = base_mode;
        if (run_en) begin
          if (!tick_wrap) begin
            presc_d = base_presc + PW'(1);
          end else begin
            presc_d = '0;
            if (!tick_hit) begin
              rem_d = base_rem - REM_ONE;
            end else begin
              expire_evt = 1'b1;
              if (base_mode) begin
                rem_d = base_reload;
              end else begin
                state_d = ST_DONE;
                rem_d   = '0;
              end
            end
          end
        end
      end
    end

    // Output decode from the next state so the flags register alongside it.
    always_comb begin
      busy_d   = (state_d == ST_RUN);
      done_d   = (state_d == ST_DONE);
      expire_d = expire_evt;
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= ST_IDLE;
        presc_q  <= '0;
        rem_q    <= '0;
        reload_q <= '0;
        mode_q   <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        expire_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        presc_q  <= presc_d;
        rem_q    <= rem_d;
        reload_q <= reload_d;
        mode_q   <= mode_d;
        busy_q   <= busy_d;
        done_q   <= done_d;
        expire_q <= expire_d;
      end
    end

    assign busy[i]   = busy_q;
    assign done[i]   = done_q;
    assign expire[i] = expire_q;
  end

endmodule

// File: tb/tb_delay_timer_multi.sv
// tb_delay_timer_multi: directed plus random stimulus for delay_timer_multi,
// checked every cycle against a deadline-based reference model.
module tb_delay_timer_multi;

  localparam int F   = 4;
  localparam int NCH = 4;
  localparam int DW  = 16;
`ifdef DELAY_TIMER_MULTI_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    start, abort, periodic, pause_v;
  logic [NCH*DW-1:0] delay_us;
  logic [NCH-1:0]    busy, done, expire;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: absolute cycle of the next expiry per channel.
  bit m_busy[NCH];
  bit m_done[NCH];
  bit m_exp[NCH];
  int deadline[NCH];
  int period[NCH];

  int exp_cnt[NCH];
  int last_exp[NCH];

  delay_timer_multi #(.FREQ_MHZ(F), .NUM_CH(NCH), .DELAY_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .periodic (periodic),
    .delay_us (delay_us),
`ifdef DELAY_TIMER_MULTI_PAUSE_EN
    .pause    (pause_v),
`endif
    .busy     (busy),
    .done     (done),
    .expire   (expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic set_delay(input int ch, input int val);
    delay_us[ch*DW +: DW] = DW'(val);
  endtask

  // Advance the model by the cycle whose inputs are currently applied.
  task automatic model_update();
    int  d;
    bit  p;
    for (int i = 0; i < NCH; i++) begin
      d = int'(delay_us[i*DW +: DW]);
      p = PAUSE_EN && pause_v[i];
      m_exp[i] = 1'b0;
      if (rst) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
      end else if (abort[i]) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
      end else if (start[i]) begin
        if (d == 0) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
          m_exp[i]  = 1'b1;
        end else begin
          m_busy[i]   = 1'b1;
          m_done[i]   = 1'b0;
          deadline[i] = cyc + d * F + (p ? 1 : 0);
          period[i]   = periodic[i] ? d * F : 0;
        end
      end else if (m_busy[i]) begin
        if (p) begin
          deadline[i]++;
        end else if (deadline[i] == cyc + 1) begin
          m_exp[i] = 1'b1;
          if (period[i] != 0) begin
            deadline[i] += period[i];
          end else begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] eb, ed, ee;
    for (int i = 0; i < NCH; i++) begin
      eb[i] = m_busy[i];
      ed[i] = m_done[i];
      ee[i] = m_exp[i];
    end
    chk_vec("busy", busy, eb);
    chk_vec("done", done, ed);
    chk_vec("expire", expire, ee);
    for (int i = 0; i < NCH; i++) begin
      if (expire[i] === 1'b1) begin
        exp_cnt[i]++;
        last_exp[i] = cyc;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_strobes();
    start = '0;
    abort = '0;
  endtask

  initial begin
    int t0;
    int base[NCH];

    rst = 1'b1; start = '0; abort = '0; periodic = '0; pause_v = '0; delay_us = '0;
    for (int i = 0; i < NCH; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_exp[i] = 0;
      deadline[i] = 0; period[i] = 0; exp_cnt[i] = 0; last_exp[i] = -1;
    end
    step();
    step();
    rst = 1'b0;
    chk_vec("reset_busy", busy, '0);
    chk_vec("reset_done", done, '0);
    chk_vec("reset_expire", expire, '0);

    // one-shot, delay 3
    t0 = cyc; base[0] = exp_cnt[0];
    set_delay(0, 3); periodic[0] = 1'b0; start[0] = 1'b1;
    step(); clear_strobes();
    chk("t1_busy_c1", int'(busy[0]), 1);
    run_until(t0 + 16);
    chk("t1_exp_cycle", last_exp[0] - t0, 12);
    chk("t1_exp_count", exp_cnt[0] - base[0], 1);
    chk("t1_done", int'(done[0]), 1);
    chk("t1_busy_end", int'(busy[0]), 0);

    // periodic, delay 2, aborted in cycle 20
    t0 = cyc; base[1] = exp_cnt[1];
    set_delay(1, 2); periodic[1] = 1'b1; start[1] = 1'b1;
    step(); clear_strobes();
    run_until(t0 + 20);
    chk("t2_done_running", int'(done[1]), 0);
    abort[1] = 1'b1;
    step(); clear_strobes();
    chk("t2_busy_after_abort", int'(busy[1]), 0);
    run_until(t0 + 30);
    chk("t2_exp_count", exp_cnt[1] - base[1], 2);
    chk("t2_last_exp", last_exp[1] - t0, 16);

    // restart: delay 5 at 0, delay 2 at 10
    t0 = cyc; base[0] = exp_cnt[0];
    set_delay(0, 5); periodic[0] = 1'b0; start[0] = 1'b1;
    step(); clear_strobes();
    run_until(t0 + 10);
    set_delay(0, 2); start[0] = 1'b1;
    step(); clear_strobes();
    run_until(t0 + 24);
    chk("t3_exp_count", exp_cnt[0] - base[0], 1);
    chk("t3_exp_cycle", last_exp[0] - t0, 18);

    // zero delay in periodic mode
    t0 = cyc; base[2] = exp_cnt[2];
    set_delay(2, 0); periodic[2] = 1'b1; start[2] = 1'b1;
    step(); clear_strobes();
    run_until(t0 + 10);
    chk("t4_exp_cycle", last_exp[2] - t0, 1);
    chk("t4_exp_count", exp_cnt[2] - base[2], 1);
    chk("t4_done", int'(done[2]), 1);
    chk("t4_busy", int'(busy[2]), 0);

    // start and abort together
    base[3] = exp_cnt[3];
    set_delay(3, 4); periodic[3] = 1'b0; start[3] = 1'b1;
    step(); clear_strobes();
    run_until(cyc + 3);
    start[3] = 1'b1; abort[3] = 1'b1;
    step(); clear_strobes();
    chk("t5_busy", int'(busy[3]), 0);
    chk("t5_done", int'(done[3]), 0);
    run_until(cyc + 20);
    chk("t5_no_expire", exp_cnt[3] - base[3], 0);

    // independence: delays 1..4 on all channels
    abort = '1; step(); clear_strobes();
    t0 = cyc;
    for (int i = 0; i < NCH; i++) begin
      set_delay(i, i + 1); periodic[i] = 1'b0; start[i] = 1'b1;
    end
    step(); clear_strobes();
    run_until(t0 + 20);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("t6_exp_cycle_ch%0d", i), last_exp[i] - t0, 4 * (i + 1));

    // same start, reset in cycle 6
    abort = '1; step(); clear_strobes();
    t0 = cyc;
    for (int i = 0; i < NCH; i++) begin
      base[i] = exp_cnt[i]; start[i] = 1'b1;
    end
    step(); clear_strobes();
    run_until(t0 + 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_vec("t7_busy_rst", busy, '0);
    chk_vec("t7_done_rst", done, '0);
    chk_vec("t7_expire_rst", expire, '0);
    run_until(t0 + 24);
    chk("t7_ch0_count", exp_cnt[0] - base[0], 1);
    chk("t7_ch0_cycle", last_exp[0] - t0, 4);
    for (int i = 1; i < NCH; i++)
      chk($sformatf("t7_no_exp_ch%0d", i), exp_cnt[i] - base[i], 0);

`ifdef DELAY_TIMER_MULTI_PAUSE_EN
    // pause cycles 3..7 stretch delay 2 from cycle 8 to 13
    t0 = cyc; base[0] = exp_cnt[0];
    set_delay(0, 2); periodic[0] = 1'b0; start[0] = 1'b1;
    step(); clear_strobes();
    run_until(t0 + 3);
    pause_v[0] = 1'b1;
    run_until(t0 + 8);
    pause_v[0] = 1'b0;
    run_until(t0 + 18);
    chk("t8_pause_exp_cycle", last_exp[0] - t0, 13);
    chk("t8_pause_exp_count", exp_cnt[0] - base[0], 1);
`endif

    // random traffic
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NCH; i++) begin
        start[i] = ($urandom_range(0, 19) == 0);
        abort[i] = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 3) == 0) set_delay(i, int'($urandom_range(0, 5)));
        if ($urandom_range(0, 3) == 0) periodic[i] = 1'($urandom_range(0, 1));
        pause_v[i] = PAUSE_EN && ($urandom_range(0, 3) == 0);
      end
      step();
    end
    rst = 1'b0; clear_strobes(); pause_v = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
